// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and its program store.
//   DW / AW / DEPTH : instruction width, address width, store depth
//   state_e         : loader FSM states
//   CKSUM_TARGET    : an image is good when the 8-bit sum of its 16 words
//                     plus the trailing checksum byte wraps to this value
package program_loader_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [DW-1:0] CKSUM_TARGET = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_GOOD  = 3'd3,
    ST_BAD   = 3'd4
  } state_e;

endpackage

// File: rtl/program_loader_ram_8bit_16word.sv
// 16 x 8 program store: synchronous write, combinational read.
// Read side is pin-compatible with the ROM it replaces.
//   CK       : clock
//   WE/WAD/WD: write enable, write address, write data (posedge)
//   AD/Q     : CPU fetch address and data, Q = mem[AD]
// No reset: contents survive RST and power up as an all-zero (NOP) image.
module ram_8bit_16word
  import program_loader_pkg::*;
(
  input  logic          CK,
  input  logic          WE,
  input  logic [AW-1:0] WAD,
  input  logic [DW-1:0] WD,
  input  logic [AW-1:0] AD,
  output logic [DW-1:0] Q
);

  logic [DW-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge CK) begin
    if (WE) mem_q[WAD] <= WD;
  end

  // A read of the word being written this cycle returns the old value.
  assign Q = mem_q[AD];

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a 16-byte image plus checksum over VALID/READY,
// writes it into the program store and releases the CPU on a good image.
//   CK, RST         : clock, synchronous active-high reset
//   START           : begin or restart a load (wins over VALID)
//   VALID/DATA/READY: byte stream handshake
//   AD/Q            : CPU fetch port into the program store
//   CPU_HOLD        : keep CPU stalled until a good image is present
//   DONE/ERR        : last load checksum good / bad
//   WCNT            : bytes written in the current load (0..16)
//
// state    | meaning
// ST_IDLE  | after reset, waiting for START
// ST_LOAD  | accepting the 16 image bytes
// ST_CHECK | waiting for the checksum byte
// ST_GOOD  | image good, CPU released
// ST_BAD   | checksum failed, CPU held
module program_loader
  import program_loader_pkg::*;
(
  input  logic          CK,
  input  logic          RST,
  input  logic          START,
  input  logic          VALID,
  input  logic [DW-1:0] DATA,
  output logic          READY,
  input  logic [AW-1:0] AD,
  output logic [DW-1:0] Q,
  output logic          CPU_HOLD,
  output logic          DONE,
  output logic          ERR,
  output logic [AW:0]   WCNT
);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] sum_q;
  logic [AW:0]   wcnt_q;
  logic          hold_q, done_q, err_q;

  logic          accept;
  logic          wr_en;
  logic [DW-1:0] sum_d;

  assign READY  = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !START;
  assign accept = VALID && READY;
  assign wr_en  = accept && (state_q == ST_LOAD);
  // Same adder serves the running sum in LOAD and the final check in CHECK.
  assign sum_d  = sum_q + DATA;

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sum_q   <= '0;
      wcnt_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (START) begin
      // Start from any state, including an abort mid-load.
      state_q <= ST_LOAD;
      addr_q  <= '0;
      sum_q   <= '0;
      wcnt_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            addr_q <= addr_q + 1'b1;
            wcnt_q <= wcnt_q + 1'b1;
            sum_q  <= sum_d;
            if (addr_q == AW'(DEPTH - 1)) state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (sum_d == CKSUM_TARGET) begin
              state_q <= ST_GOOD;
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_BAD;
              err_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign CPU_HOLD = hold_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign WCNT     = wcnt_q;

  ram_8bit_16word u_ram (
    .CK  (CK),
    .WE  (wr_en),
    .WAD (addr_q),
    .WD  (DATA),
    .AD  (AD),
    .Q   (Q)
  );

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       VALID = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic       READY;
  logic [3:0] AD = 4'h0;
  logic [7:0] Q;
  logic       CPU_HOLD, DONE, ERR;
  logic [4:0] WCNT;

  program_loader dut (
    .CK(CK), .RST(RST), .START(START), .VALID(VALID), .DATA(DATA),
    .READY(READY), .AD(AD), .Q(Q), .CPU_HOLD(CPU_HOLD), .DONE(DONE),
    .ERR(ERR), .WCNT(WCNT)
  );

  always #5 CK = ~CK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the loader should look like from the outside.
  logic [7:0] m_mem [16];
  bit         m_busy;   // a load is in progress (image bytes or checksum pending)
  int         m_count;  // image bytes received in the current load
  int         m_sum;
  bit         m_done, m_err;

  function automatic bit m_ready(input bit st);
    return m_busy && !st;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_count = 0; m_sum = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit st, input bit v, input logic [7:0] d);
    if (st) begin
      m_busy = 1; m_count = 0; m_sum = 0; m_done = 0; m_err = 0;
    end else if (m_busy && v) begin
      if (m_count < 16) begin
        m_mem[m_count] = d;
        m_sum = (m_sum + d) % 256;
        m_count++;
      end else begin
        m_busy = 0;
        if ((m_sum + d) % 256 == 0) m_done = 1;
        else m_err = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".hold"}, CPU_HOLD, !m_done);
    check({tag, ".done"}, DONE, m_done);
    check({tag, ".err"},  ERR, m_err);
    check({tag, ".wcnt"}, WCNT, m_count);
  endtask

  // One clock cycle with the given inputs; checks READY and the old-value
  // read before the edge, and all outputs after it.
  task automatic step(input bit st, input bit v, input logic [7:0] d);
    START = st; VALID = v; DATA = d;
    if (m_busy && m_count < 16) AD = 4'(m_count);
    else AD = 4'($urandom_range(0, 15));
    #1;
    check("ready", READY, m_ready(st));
    check("q_pre", Q, m_mem[AD]);
    @(posedge CK);
    model_edge(st, v, d);
    #1;
    check_outputs("post");
    check("q_post", Q, m_mem[AD]);
    START = 0; VALID = 0;
  endtask

  task automatic do_reset();
    RST = 1; START = 0; VALID = 0;
    @(posedge CK);
    model_reset();
    #1;
    RST = 0;
    check_outputs("rst");
    check("rst.ready", READY, 0);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      AD = 4'(a);
      #0.5;
      check(tag, Q, m_mem[a]);
    end
  endtask

  // Offer a byte with random idle cycles until it is taken.
  task automatic send(input logic [7:0] d, input int gap_pct);
    bit taken = 0;
    for (int i = 0; i < 64 && !taken; i++) begin
      bit v;
      v = ($urandom_range(0, 99) >= gap_pct);
      taken = v && m_ready(0);
      step(0, v, v ? d : 8'($urandom));
    end
    check("send.taken", taken, 1);
  endtask

  task automatic load_image(input logic [7:0] img [16], input logic [7:0] ck, input int gap_pct);
    step(1, 0, 8'h00);
    for (int i = 0; i < 16; i++) send(img[i], gap_pct);
    send(ck, gap_pct);
  endtask

  logic [7:0] img [16];
  int s;

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    model_reset();

    // Reset state and power-up contents.
    do_reset();
    check_mem("por_mem");

    // Ignored input in IDLE.
    for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom));
    check_mem("idle_ign_mem");

    // Good load, no gaps.
    for (int i = 0; i < 16; i++) img[i] = 8'h01;
    load_image(img, 8'hF0, 0);
    check("good.done_const", DONE, 1);
    check("good.hold_const", CPU_HOLD, 0);
    check("good.wcnt_const", WCNT, 16);
    check_mem("good_mem");

    // Ignored input in GOOD.
    for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom));
    check_mem("good_ign_mem");

    // Bad load.
    load_image(img, 8'hEF, 0);
    check("bad.err_const", ERR, 1);
    check("bad.done_const", DONE, 0);
    check("bad.hold_const", CPU_HOLD, 1);
    check_mem("bad_mem");

    // Gapped stream, restart with START+VALID after 5 bytes.
    step(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) send(8'($urandom), 40);
    step(1, 1, 8'hAA);
    check("restart.wcnt_const", WCNT, 0);
    img[0] = 8'h3C;
    for (int i = 1; i < 16; i++) img[i] = 8'h00;
    for (int i = 0; i < 16; i++) send(img[i], 40);
    send(8'hC4, 40);
    check("restart.done_const", DONE, 1);
    AD = 4'h0; #0.5;
    check("restart.mem0_const", Q, 8'h3C);
    check_mem("restart_mem");

    // Reload from GOOD interrupted by RST after 8 bytes.
    step(1, 0, 8'h00);
    for (int i = 0; i < 8; i++) send(8'($urandom), 20);
    do_reset();
    check("rst_mid.hold_const", CPU_HOLD, 1);
    check("rst_mid.done_const", DONE, 0);
    check_mem("rst_mid_mem");

    // Random loads with random gaps, good or corrupted checksum.
    for (int n = 0; n < 6; n++) begin
      s = 0;
      for (int i = 0; i < 16; i++) begin
        img[i] = 8'($urandom);
        s = (s + img[i]) % 256;
      end
      load_image(img, ($urandom_range(0, 1) == 1) ? 8'((256 - s) % 256)
                                                  : 8'((257 - s) % 256), 30);
      check_mem("rand_mem");
      for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
